// File: rtl/hall_commutator.sv
// Six-step BLDC commutator: syncs and deglitches hall inputs, registers phase selects, tracks position/period/stall.
// Latency: hall pin change to hf is 2+FILTER_LEN cycles; u/z follow hf one cycle later.
// Backpressure: none; free-running, with outputs forced off while disabled, faulted or not yet locked.
module hall_commutator #(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 16,
    parameter int PER_W      = 20,
    parameter int STALL_CYC  = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       hall,
    input  logic             en,
    input  logic             dir,
    input  logic             clr_fault,
    output logic [2:0]       u,
    output logic [2:0]       z,
    output logic             fault,
    output logic             stall,
    output logic [CNT_W-1:0] hall_pos,
    output logic [PER_W-1:0] period
);

    localparam int FC_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [FC_W-1:0]  FLC      = FC_W'(FILTER_LEN);
    localparam logic [PER_W-1:0] PER_MAX  = '1;
    localparam logic [PER_W-1:0] STALL_TH = PER_W'(STALL_CYC);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

    // 000 and 111 never occur on healthy 120-degree sensors
    function automatic logic f_valid(input logic [2:0] h);
        return (h != 3'b000) && (h != 3'b111);
    endfunction

    // Successor in the forward rotation order
    function automatic logic [2:0] f_next(input logic [2:0] h);
        case (h)
            3'b101:  return 3'b100;
            3'b100:  return 3'b110;
            3'b110:  return 3'b010;
            3'b010:  return 3'b011;
            3'b011:  return 3'b001;
            3'b001:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Predecessor in the forward rotation order
    function automatic logic [2:0] f_prev(input logic [2:0] h);
        case (h)
            3'b101:  return 3'b001;
            3'b100:  return 3'b101;
            3'b110:  return 3'b100;
            3'b010:  return 3'b110;
            3'b011:  return 3'b010;
            3'b001:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Forward commutation table, returns {u, z}
    function automatic logic [5:0] f_fwd(input logic [2:0] h);
        case (h)
            3'b101:  return {3'b100, 3'b001};
            3'b100:  return {3'b100, 3'b010};
            3'b110:  return {3'b010, 3'b100};
            3'b010:  return {3'b010, 3'b001};
            3'b011:  return {3'b001, 3'b010};
            3'b001:  return {3'b001, 3'b100};
            default: return {3'b000, 3'b111};
        endcase
    endfunction

    logic [2:0]       r_sync1, r_sync2, r_last, r_hf;
    logic             r_sv1, r_sv2, r_hf_vld;
    logic [FC_W-1:0]  r_fcnt;
    logic [FC_W-1:0]  w_len;
    logic             w_acc, w_chg, w_hf_vld_nxt;
    logic [2:0]       w_hf_nxt;
    logic [5:0]       w_fwd;
    logic [2:0]       w_u_rev;
    logic [PER_W-1:0] w_per_nxt;

    state_t           r_state;
    logic [2:0]       r_u, r_z;
    logic [CNT_W-1:0] r_pos;
    logic [PER_W-1:0] r_per, r_scnt;

    // Run length of the current synced sample; r_fcnt==0 means no sample seen yet
    always_comb begin
        w_len = FC_W'(1);
        if ((r_sync2 == r_last) && (r_fcnt != '0)) begin
            w_len = (r_fcnt == FLC) ? r_fcnt : r_fcnt + FC_W'(1);
        end
    end

    assign w_acc        = r_sv2 && (w_len == FLC);
    assign w_chg        = w_acc && r_hf_vld && (r_sync2 != r_hf);
    assign w_hf_vld_nxt = r_hf_vld | w_acc;
    assign w_hf_nxt     = w_acc ? r_sync2 : r_hf;
    assign w_fwd        = f_fwd(r_hf);
    assign w_u_rev      = ~(w_fwd[5:3] | w_fwd[2:0]);
    assign w_per_nxt    = (r_scnt == PER_MAX) ? PER_MAX : r_scnt + PER_W'(1);

    // Two-flop synchroniser plus run-length deglitch filter; r_sv* masks the reset contents of the sync chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_sv1    <= 1'b0;
            r_sv2    <= 1'b0;
            r_last   <= 3'b000;
            r_fcnt   <= '0;
            r_hf     <= 3'b000;
            r_hf_vld <= 1'b0;
        end else begin
            r_sync1 <= hall;
            r_sync2 <= r_sync1;
            r_sv1   <= 1'b1;
            r_sv2   <= r_sv1;
            r_last  <= r_sync2;
            r_fcnt  <= r_sv2 ? w_len : '0;
            if (w_acc) begin
                r_hf     <= r_sync2;
                r_hf_vld <= 1'b1;
            end
        end
    end

    // Control FSM with step accounting, stall counter and registered phase selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_u     <= 3'b000;
            r_z     <= 3'b111;
            r_pos   <= '0;
            r_per   <= PER_MAX;
            r_scnt  <= '0;
        end else begin
            r_scnt <= w_per_nxt;
            case (r_state)
                ST_INIT: begin
                    if (w_hf_vld_nxt) begin
                        r_state <= f_valid(w_hf_nxt) ? ST_RUN : ST_FAULT;
                    end
                end
                ST_RUN: begin
                    if (w_chg) begin
                        if (!f_valid(r_sync2)) begin
                            r_state <= ST_FAULT;
                        end else if (r_sync2 == f_next(r_hf)) begin
                            r_pos  <= r_pos + CNT_W'(1);
                            r_per  <= w_per_nxt;
                            r_scnt <= '0;
                        end else if (r_sync2 == f_prev(r_hf)) begin
                            r_pos  <= r_pos - CNT_W'(1);
                            r_per  <= w_per_nxt;
                            r_scnt <= '0;
                        end else begin
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clr_fault && r_hf_vld && f_valid(r_hf)) begin
                        r_state <= ST_INIT;
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            if (en && (r_state == ST_RUN) && f_valid(r_hf)) begin
                r_u <= dir ? w_u_rev : w_fwd[5:3];
                r_z <= w_fwd[2:0];
            end else begin
                r_u <= 3'b000;
                r_z <= 3'b111;
            end
        end
    end

    assign u        = r_u;
    assign z        = r_z;
    assign fault    = (r_state == ST_FAULT);
    assign stall    = (r_scnt >= STALL_TH);
    assign hall_pos = r_pos;
    assign period   = r_per;

endmodule

// File: tb/tb_hall_commutator.sv
// Bench for hall_commutator: table-driven step vectors through a scoreboard queue, plus hand-written corner sequences.
// Latency: checks sample 1 ns after the clock edge on which the expected value should appear.
// Backpressure: n/a; a watchdog bounds total run time.
module tb_hall_commutator;

    localparam int FL    = 4;
    localparam int CNT_W = 16;
    localparam int PER_W = 9;
    localparam int STALL = 300;
    localparam int LAT   = FL + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       hall;
    logic             en, dir, clr_fault;
    logic [2:0]       u, z;
    logic             fault, stall;
    logic [CNT_W-1:0] hall_pos;
    logic [PER_W-1:0] period;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] hall;
        logic       dir;
        logic [2:0] u;
        logic [2:0] z;
        int         pos;
        logic       chk_per;
    } vec_t;

    typedef struct {
        logic [2:0] u;
        logic [2:0] z;
        int         pos;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    hall_commutator #(
        .FILTER_LEN(FL),
        .CNT_W     (CNT_W),
        .PER_W     (PER_W),
        .STALL_CYC (STALL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall     (hall),
        .en       (en),
        .dir      (dir),
        .clr_fault(clr_fault),
        .u        (u),
        .z        (z),
        .fault    (fault),
        .stall    (stall),
        .hall_pos (hall_pos),
        .period   (period)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [2:0] eu, input logic [2:0] ez, input int epos, input logic ef);
        exp_t e;
        e.u = eu; e.z = ez; e.pos = epos; e.fault = ef;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " u"}, int'(u), int'(e.u));
            chk({tag, " z"}, int'(z), int'(e.z));
            chk({tag, " pos"}, int'($signed(hall_pos)), e.pos);
            chk({tag, " fault"}, int'(fault), int'(e.fault));
        end
    endtask

    initial begin
        vecs[0]  = '{3'b100, 1'b0, 3'b100, 3'b010, 1, 1'b0};
        vecs[1]  = '{3'b110, 1'b0, 3'b010, 3'b100, 2, 1'b1};
        vecs[2]  = '{3'b010, 1'b0, 3'b010, 3'b001, 3, 1'b1};
        vecs[3]  = '{3'b011, 1'b0, 3'b001, 3'b010, 4, 1'b1};
        vecs[4]  = '{3'b001, 1'b0, 3'b001, 3'b100, 5, 1'b1};
        vecs[5]  = '{3'b101, 1'b0, 3'b100, 3'b001, 6, 1'b1};
        vecs[6]  = '{3'b001, 1'b1, 3'b010, 3'b100, 5, 1'b1};
        vecs[7]  = '{3'b011, 1'b1, 3'b100, 3'b010, 4, 1'b1};
        vecs[8]  = '{3'b010, 1'b1, 3'b100, 3'b001, 3, 1'b1};
        vecs[9]  = '{3'b110, 1'b1, 3'b001, 3'b100, 2, 1'b1};
        vecs[10] = '{3'b100, 1'b1, 3'b001, 3'b010, 1, 1'b1};
        vecs[11] = '{3'b101, 1'b1, 3'b010, 3'b001, 0, 1'b1};

        rst_n = 1'b0; hall = 3'b101; en = 1'b1; dir = 1'b0; clr_fault = 1'b0;

        // Reset state
        wait_cyc(3);
        chk("rst u", int'(u), 0);
        chk("rst z", int'(z), 7);
        chk("rst fault", int'(fault), 0);
        chk("rst stall", int'(stall), 0);
        chk("rst pos", int'(hall_pos), 0);
        chk("rst period", int'(period), (1 << PER_W) - 1);

        // Lock onto the held code: outputs appear exactly at cycle 2+FL+1
        rst_n = 1'b1;
        sb_push(3'b100, 3'b001, 0, 1'b0);
        wait_cyc(LAT - 1);
        chk("lock early u", int'(u), 0);
        wait_cyc(1);
        sb_check("lock");

        // Forward revolution then reverse revolution, 50 cycles per step
        for (int i = 0; i < 12; i++) begin
            hall = vecs[i].hall;
            dir  = vecs[i].dir;
            sb_push(vecs[i].u, vecs[i].z, vecs[i].pos, 1'b0);
            wait_cyc(LAT);
            sb_check($sformatf("step%0d", i));
            if (vecs[i].chk_per)
                chk($sformatf("step%0d period", i), int'(period), 50);
            wait_cyc(50 - LAT);
        end

        // Back to forward at 101; en gating takes effect the next cycle
        dir = 1'b0;
        wait_cyc(1);
        chk("dir0 u", int'(u), 3'b100);
        en = 1'b0;
        wait_cyc(1);
        chk("en0 u", int'(u), 0);
        chk("en0 z", int'(z), 7);
        en = 1'b1;
        wait_cyc(1);
        chk("en1 u", int'(u), 3'b100);

        // Glitch shorter than the filter is rejected
        hall = 3'b110;
        wait_cyc(FL - 1);
        hall = 3'b101;
        sb_push(3'b100, 3'b001, 0, 1'b0);
        wait_cyc(12);
        sb_check("glitch");

        // Skip from 101 to 010 faults and holds position
        hall = 3'b010;
        sb_push(3'b000, 3'b111, 0, 1'b1);
        wait_cyc(LAT);
        sb_check("skip");

        // clr_fault ignored while the code is invalid
        hall = 3'b000;
        wait_cyc(10);
        clr_fault = 1'b1;
        wait_cyc(1);
        clr_fault = 1'b0;
        wait_cyc(2);
        chk("clr invalid fault", int'(fault), 1);

        // clr_fault with a valid code: INIT then RUN at 010
        hall = 3'b010;
        wait_cyc(10);
        chk("pre clr fault", int'(fault), 1);
        clr_fault = 1'b1;
        wait_cyc(1);
        clr_fault = 1'b0;
        chk("clr valid fault", int'(fault), 0);
        sb_push(3'b010, 3'b001, 0, 1'b0);
        wait_cyc(2);
        sb_check("recover");

        // Long hold: stall asserts and the counter saturates
        wait_cyc(STALL + 20);
        chk("hold stall", int'(stall), 1);
        wait_cyc(300);
        hall = 3'b011;
        wait_cyc(LAT - 2);
        chk("pre step stall", int'(stall), 1);
        wait_cyc(1);
        chk("post step stall", int'(stall), 0);
        chk("sat period", int'(period), (1 << PER_W) - 1);
        chk("stall pos", int'(hall_pos), 1);

        // Stall threshold boundary and exact period measurement
        wait_cyc(STALL - 1);
        chk("thr-1 stall", int'(stall), 0);
        wait_cyc(1);
        chk("thr stall", int'(stall), 1);
        hall = 3'b001;
        wait_cyc(LAT - 1);
        chk("meas period", int'(period), STALL + LAT - 1);
        chk("meas stall", int'(stall), 0);
        sb_push(3'b001, 3'b100, 2, 1'b0);
        wait_cyc(1);
        sb_check("meas");

        // Asynchronous reset mid-run, no clock edge in between
        rst_n = 1'b0;
        #2;
        chk("arst u", int'(u), 0);
        chk("arst z", int'(z), 7);
        chk("arst pos", int'(hall_pos), 0);
        chk("arst period", int'(period), (1 << PER_W) - 1);
        chk("arst fault", int'(fault), 0);
        chk("sb drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
